temp_filter: RTL and testbench
==============================

Name: temp_filter

Overview:
- Upstream conditioning stage for the incubator power controller.
- Accepts raw 8-bit temperature samples (unsigned, °C) from the sensor interface on a valid strobe.
- Produces the smoothed, outlier-filtered 8-bit T bus consumed by the heater/cooler state machine.
- Flags a stale sensor when no samples arrive within a timeout window.

Parameters:
- LOG2_N, 2, log2 of moving-average window depth. N = 2^LOG2_N samples; legal range 1..4.
- RESET_T, 25, value preloaded into every window slot and onto T at reset. Sits in the controller's idle band.
- MAX_STEP, 10, maximum |sample − T| accepted without rejection.
- REJ_LIMIT, 3, consecutive rejections after which the next out-of-range sample is force-accepted.
- TIMEOUT, 1000, cycles without sample_valid before stale asserts. Legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  reset, asynchronous, active-low.
- sample  in  8  raw temperature sample, unsigned °C.
- sample_valid  in  1  single-cycle strobe qualifying sample.
- T  out  8  filtered temperature, registered.
- t_valid  out  1  one-cycle pulse, high the cycle T is updated.
- sample_rej  out  1  one-cycle pulse, high when a sample is rejected as an outlier.
- stale  out  1  level, high while no sample has arrived for TIMEOUT cycles.

Behaviour:
- Reset is asynchronous, active-low, on rstN; single clock clk. On rstN low, immediately:
  - all N window slots = RESET_T; sum = N*RESET_T; write index = 0;
  - T = RESET_T; t_valid = 0; sample_rej = 0; stale = 0;
  - reject counter = 0; watchdog counter = 0.
- Window is a circular buffer of N 8-bit slots with a running sum of width 8+LOG2_N. The sum never overflows: 255*16 fits in 12 bits.
- Accept path (sample_valid = 1 and sample accepted), edge k:
  - sum ← sum − slot[idx] + sample;
  - slot[idx] ← sample;
  - idx ← idx+1, wrapping from N−1 to 0.
- T ← new_sum >> LOG2_N (floor) and t_valid = 1 during cycle k+1. Latency is one cycle, strobe to T/t_valid.
- Outlier decision:
  - Computed combinationally against the current registered T with 9-bit absolute difference.
  - diff ≤ MAX_STEP: accept; reject counter ← 0.
  - diff > MAX_STEP and reject counter < REJ_LIMIT: reject. Window, sum and T unchanged; sample_rej = 1 next cycle; reject counter +1.
  - diff > MAX_STEP and reject counter = REJ_LIMIT: accept (genuine step change); reject counter ← 0.
- sample_valid = 0: no window change; t_valid = 0; sample_rej = 0.
- Watchdog:
  - Counter increments every cycle with no sample_valid and saturates at TIMEOUT.
  - Any sample_valid, accepted or rejected, clears the counter to 0.
  - stale = (counter == TIMEOUT), registered.
  - sample_valid on the cycle the counter would reach TIMEOUT wins: counter clears and stale stays 0.
  - stale deasserts the cycle after the first sample_valid.
- T holds its last value while stale; the filter does not invalidate it.
- Back-to-back sample_valid every cycle is supported at full rate with no stall.

Optional Feature:
- Macro: TEMP_FILTER_REJECT_EN.
- Defined: outlier rejection and the reject counter behave as above.
- Undefined: every valid sample is accepted; reject counter is not built; sample_rej is tied to 0; MAX_STEP and REJ_LIMIT are ignored.

Test Plan:
1. Reset with defaults -> T=25, t_valid=0, sample_rej=0, stale=0; pulse rstN low mid-run with T=33 -> T=25 immediately, before any clock edge.
2. Four strobes of sample=33 from reset -> T=27, 29, 31, 33 on successive updates, each with a one-cycle t_valid pulse one cycle after the strobe.
3. REJECT_EN on, T=33 steady, sample=60 four times -> first three give sample_rej pulses and T stays 33; fourth is accepted, T=39 (sum 159>>2).
4. REJECT_EN off, same stimulus -> all four accepted; T=39, 46, 53, 60; sample_rej never asserts.
5. No sample_valid for 1000 cycles -> stale=1 after cycle 1000; one strobe -> stale=0 next cycle; strobe on exactly the 1000th idle cycle -> stale never asserts.
6. Fill the window with 255 (LOG2_N=2, REJECT_EN off) -> T=255 without overflow; then one sample=0 -> T=191.

Source files
------------

// File: rtl/temp_filter_if.sv
// Sensor-to-controller bus for the temperature filter.
// master: sensor side (drives sample/sample_valid); slave: the filter.
interface temp_filter_if;
  logic [7:0] sample;
  logic       sample_valid;
  logic [7:0] T;
  logic       t_valid;
  logic       sample_rej;
  logic       stale;

  modport master (
    output sample,
    output sample_valid,
    input  T,
    input  t_valid,
    input  sample_rej,
    input  stale
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output T,
    output t_valid,
    output sample_rej,
    output stale
  );
endinterface

// File: rtl/temp_filter.sv
// Moving-average temperature filter with outlier rejection and stale watchdog.
// Ports: clk, rstN (async active-low), bus (temp_filter_if.slave: sample,
// sample_valid in; T, t_valid, sample_rej, stale out).
// Macro TEMP_FILTER_REJECT_EN builds the outlier rejector; otherwise every
// valid sample is accepted and sample_rej is tied low.
module temp_filter #(
  parameter int LOG2_N    = 2,
  parameter int RESET_T   = 25,
  parameter int MAX_STEP  = 10,
  parameter int REJ_LIMIT = 3,
  parameter int TIMEOUT   = 1000
) (
  input  logic         clk,
  input  logic         rstN,
  temp_filter_if.slave bus
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 8 + LOG2_N;

  logic [7:0]        win [N];
  logic [SW-1:0]     sum;
  logic [LOG2_N-1:0] idx;
  logic [SW-1:0]     new_sum;
  logic              accept;
  logic              reject;

  logic [15:0]       wd_cnt;
  logic [15:0]       wd_nxt;

`ifdef TEMP_FILTER_REJECT_EN
  localparam int RW = (REJ_LIMIT > 0) ? $clog2(REJ_LIMIT + 1) : 1;

  logic [RW-1:0] rej_cnt;
  logic [8:0]    diff;
  logic          outlier;
  logic          at_limit;

  assign diff = (bus.sample >= bus.T)
              ? ({1'b0, bus.sample} - {1'b0, bus.T})
              : ({1'b0, bus.T} - {1'b0, bus.sample});
  assign outlier  = diff > 9'(MAX_STEP);
  assign at_limit = rej_cnt == RW'(REJ_LIMIT);
  // After REJ_LIMIT rejections in a row the jump is treated as real.
  assign accept = bus.sample_valid && (!outlier || at_limit);
  assign reject = bus.sample_valid && outlier && !at_limit;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rej_cnt <= '0;
    end else if (reject) begin
      rej_cnt <= rej_cnt + 1'b1;
    end else if (accept) begin
      rej_cnt <= '0;
    end
  end
`else
  assign accept = bus.sample_valid;
  assign reject = 1'b0;
`endif

  assign new_sum = sum - SW'(win[idx]) + SW'(bus.sample);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < N; i++) begin
        win[i] <= 8'(RESET_T);
      end
      sum       <= SW'(N * RESET_T);
      idx       <= '0;
      bus.T     <= 8'(RESET_T);
      bus.t_valid <= 1'b0;
    end else begin
      bus.t_valid <= accept;
      if (accept) begin
        win[idx] <= bus.sample;
        sum      <= new_sum;
        idx      <= idx + 1'b1;
        bus.T    <= new_sum[SW-1:LOG2_N];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.sample_rej <= 1'b0;
    end else begin
      bus.sample_rej <= reject;
    end
  end

  // Any strobe clears the watchdog, even on the cycle it would expire.
  always_comb begin
    wd_nxt = wd_cnt;
    if (bus.sample_valid) begin
      wd_nxt = '0;
    end else if (wd_cnt != 16'(TIMEOUT)) begin
      wd_nxt = wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wd_cnt    <= '0;
      bus.stale <= 1'b0;
    end else begin
      wd_cnt    <= wd_nxt;
      bus.stale <= wd_nxt == 16'(TIMEOUT);
    end
  end

endmodule

// File: tb/tb_temp_filter.sv
// Directed bench for temp_filter: window averaging, rejection, watchdog.
// Outlier expectations follow TEMP_FILTER_REJECT_EN.
module tb_temp_filter;

  logic clk;
  logic rstN;

  temp_filter_if bus ();

  temp_filter dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sample;
    logic       valid;
    logic [7:0] exp_t;
    logic       exp_tv;
    logic       exp_rej;
  } vec_t;

  vec_t vq[$];
  int   n_run;
  int   n_fail;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int s, input int v, input int t,
                     input int tv, input int rj);
    vec_t r;
    r.sample  = 8'(s);
    r.valid   = 1'(v);
    r.exp_t   = 8'(t);
    r.exp_tv  = 1'(tv);
    r.exp_rej = 1'(rj);
    vq.push_back(r);
  endtask

  task automatic step(input logic v, input logic [7:0] s);
    bus.sample_valid = v;
    bus.sample       = s;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    bus.sample       = 8'd0;
    rstN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].valid, vq[i].sample);
      n_run++;
      if (bus.T !== vq[i].exp_t || bus.t_valid !== vq[i].exp_tv ||
          bus.sample_rej !== vq[i].exp_rej) begin
        n_fail++;
        $display("FAIL %s[%0d]: got T=%0d tv=%0b rej=%0b, required T=%0d tv=%0b rej=%0b",
                 tag, i, bus.T, bus.t_valid, bus.sample_rej,
                 vq[i].exp_t, vq[i].exp_tv, vq[i].exp_rej);
      end
    end
    vq.delete();
  endtask

  initial begin
    bit seen;
    n_run  = 0;
    n_fail = 0;
    bus.sample       = 8'd0;
    bus.sample_valid = 1'b0;
    rstN = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    chk("reset_T", int'(bus.T), 25);
    chk("reset_tv", int'(bus.t_valid), 0);
    chk("reset_rej", int'(bus.sample_rej), 0);
    chk("reset_stale", int'(bus.stale), 0);
    do_reset();

    // ramp from reset value toward 33
    add(33, 1, 27, 1, 0); add(0, 0, 27, 0, 0);
    add(33, 1, 29, 1, 0); add(0, 0, 29, 0, 0);
    add(33, 1, 31, 1, 0); add(0, 0, 31, 0, 0);
    add(33, 1, 33, 1, 0); add(0, 0, 33, 0, 0);
    run_table("ramp");

    // async reset mid-run, no clock edge in between
    #1;
    rstN = 1'b0;
    #1;
    chk("async_T", int'(bus.T), 25);
    chk("async_tv", int'(bus.t_valid), 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    add(33, 1, 27, 1, 0); add(33, 1, 29, 1, 0);
    add(33, 1, 31, 1, 0); add(33, 1, 33, 1, 0);
`ifdef TEMP_FILTER_REJECT_EN
    add(60, 1, 33, 0, 1); add(60, 1, 33, 0, 1);
    add(60, 1, 33, 0, 1); add(60, 1, 39, 1, 0);
    add(0, 0, 39, 0, 0);
`else
    add(60, 1, 39, 1, 0); add(60, 1, 46, 1, 0);
    add(60, 1, 53, 1, 0); add(60, 1, 60, 1, 0);
    add(0, 0, 60, 0, 0);
`endif
    run_table("step");

`ifndef TEMP_FILTER_REJECT_EN
    do_reset();
    add(255, 1, 82, 1, 0);  add(255, 1, 140, 1, 0);
    add(255, 1, 197, 1, 0); add(255, 1, 255, 1, 0);
    add(0, 1, 191, 1, 0);   add(0, 0, 191, 0, 0);
    run_table("full");
`endif

    // watchdog expiry, saturation and recovery
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 999; i++) begin
      step(1'b0, 8'd0);
      if (bus.stale) seen = 1'b1;
    end
    chk("stale_early", int'(seen), 0);
    step(1'b0, 8'd0);
    chk("stale_at_1000", int'(bus.stale), 1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0);
    chk("stale_hold", int'(bus.stale), 1);
    chk("stale_T_hold", int'(bus.T), 25);
    step(1'b1, 8'd25);
    chk("stale_clear", int'(bus.stale), 0);

    // strobe lands exactly on the expiring idle cycle
    seen = 1'b0;
    for (int i = 0; i < 999; i++) begin
      step(1'b0, 8'd0);
      if (bus.stale) seen = 1'b1;
    end
    step(1'b1, 8'd25);
    if (bus.stale) seen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0);
      if (bus.stale) seen = 1'b1;
    end
    chk("stale_race", int'(seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
